// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port, synchronous-read video RAM between the display
// pixel fetch and a buffered host write port.
//
// Display fetches happen at the first column of every 2^SHIFT-wide block inside the
// visible area and always own the RAM on that cycle. Every other cycle is a write slot,
// in which the head of a small host write FIFO is retired into the RAM. Entries whose
// address is beyond the framebuffer are dropped and flagged with a one-cycle error pulse.
//
// Ports:
//   i_clk        pixel clock
//   i_rst        asynchronous, active-high reset
//   i_col_count  current column from the timing counters
//   i_row_count  current row from the timing counters
//   i_wr_valid   host write request
//   i_wr_addr    host write word address
//   i_wr_data    host write data
//   o_wr_ready   FIFO can accept this cycle (!full, or full with a pop this cycle)
//   o_wr_err     one-cycle pulse: popped entry had an out-of-range address
//   o_mem_addr   RAM address (registered)
//   o_mem_we     RAM write enable (registered)
//   o_mem_wdata  RAM write data (registered)
//   i_mem_rdata  RAM read data, valid one cycle after o_mem_addr
//   o_pixel      pixel for the counts presented three cycles earlier, 0 in blanking
//   o_active     o_pixel lies in the visible area (same alignment)

module vram_arbiter #(
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_col_count,
  input  logic [9:0]        i_row_count,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_wr_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_active
);

  localparam int unsigned BLOCK_COLS = ACTIVE_COLS >> SHIFT;
  localparam int unsigned MEM_DEPTH  = BLOCK_COLS * (ACTIVE_ROWS >> SHIFT);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    StBlank,
    StScan
  } state_e;

  // --------------------------------------------------------------------------
  // Slot decode from the raw counts
  // --------------------------------------------------------------------------
  logic              visible;
  logic              display_slot;
  logic              write_slot;
  logic [ADDR_W-1:0] fetch_addr;

  always_comb begin
    visible      = (32'(i_row_count) < ACTIVE_ROWS) && (32'(i_col_count) < ACTIVE_COLS);
    display_slot = visible && (i_col_count[SHIFT-1:0] == '0);
    fetch_addr   = ADDR_W'((32'(i_row_count) >> SHIFT) * BLOCK_COLS +
                           (32'(i_col_count) >> SHIFT));
  end

  // --------------------------------------------------------------------------
  // Region FSM: tracks blanking vs. scan and decides which cycles are write slots.
  // The registered state doubles as the first stage of the o_active pipeline.
  // --------------------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StBlank;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StBlank;
    write_slot = 1'b1;
    if (visible) begin
      state_d = StScan;
    end
    unique case (state_d)
      StBlank: write_slot = 1'b1;
      StScan:  write_slot = (i_col_count[SHIFT-1:0] != '0);
      default: write_slot = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Host write FIFO (pointers carry one extra wrap bit to tell full from empty)
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              wr_ready;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_in_range;

  localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop           = write_slot && !fifo_empty;
    // A full FIFO still accepts when its head leaves in the same cycle.
    wr_ready      = !fifo_full || pop;
    push          = i_wr_valid && wr_ready;
    head_addr     = fifo_addr[rd_ptr_q[PTR_W-1:0]];
    head_data     = fifo_data[rd_ptr_q[PTR_W-1:0]];
    head_in_range = (32'(head_addr) < MEM_DEPTH);
  end

  assign o_wr_ready = wr_ready;

  // Entry storage needs no reset: it is only read when the pointers say it is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q[PTR_W-1:0]] <= i_wr_addr;
      fifo_data[wr_ptr_q[PTR_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM command register: fetch wins, otherwise retire the FIFO head
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              wr_err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      wr_err_q <= 1'b0;
      if (display_slot) begin
        mem_addr_q <= fetch_addr;
      end else if (pop) begin
        if (head_in_range) begin
          mem_addr_q  <= head_addr;
          mem_wdata_q <= head_data;
          mem_we_q    <= 1'b1;
        end else begin
          // Out-of-range entry is consumed without touching the RAM.
          wr_err_q <= 1'b1;
        end
      end
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_wr_err    = wr_err_q;

  // --------------------------------------------------------------------------
  // Pixel pipeline: fetch flag and active flag follow the RAM latency, the hold
  // register repeats each fetched word across its block.
  // --------------------------------------------------------------------------
  logic              fetch_q1;
  logic              fetch_q2;
  logic              active_q2;
  logic              active_q3;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] pixel_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_q1  <= 1'b0;
      fetch_q2  <= 1'b0;
      active_q2 <= 1'b0;
      active_q3 <= 1'b0;
      hold_q    <= '0;
      pixel_q   <= '0;
    end else begin
      fetch_q1  <= display_slot;
      fetch_q2  <= fetch_q1;
      active_q2 <= (state_q == StScan);
      active_q3 <= active_q2;
      if (fetch_q2) begin
        hold_q <= i_mem_rdata;
      end
      if (!active_q2) begin
        pixel_q <= '0;
      end else if (fetch_q2) begin
        pixel_q <= i_mem_rdata;
      end else begin
        pixel_q <= hold_q;
      end
    end
  end

  assign o_pixel  = pixel_q;
  assign o_active = active_q3;

endmodule
